// File: rtl/axi4_memory_pipe.sv
// -----------------------------------------------------------------------------
// axi4_memory_pipe
//
// Pipelined single-port backing store sitting between the AXI4 slave channel
// FSMs and the storage array. It accepts one read or write request per cycle
// and returns exactly one response per accepted request, in acceptance order.
// Responses go through a first-word-fall-through FIFO that the consumer can
// backpressure.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   request word-address width
//   DEPTH        number of words (<= 2**ADDR_WIDTH)
//   READ_LATENCY accept-to-response cycles, 1..4
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   req_valid      request present
//   req_ready      request can be accepted this cycle
//   req_we         1 = write, 0 = read
//   req_addr       zero-based word address
//   req_wdata      write data
//   req_wstrb      byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid      response present
//   rsp_ready      consumer takes the response
//   rsp_rdata      read data (0 for writes and for errored reads)
//   rsp_is_write   response belongs to a write
//   rsp_err        request address was >= DEPTH
// -----------------------------------------------------------------------------
module axi4_memory_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_is_write,
   output logic                    rsp_err
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int RSP_DEPTH  = READ_LATENCY + 1;
   localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W      = $clog2(RSP_DEPTH);
   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Address limit one bit wider than the address so DEPTH == 2**ADDR_WIDTH
   // still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   typedef struct packed {
      logic                  is_write;
      logic                  err;
      logic [DATA_WIDTH-1:0] rdata;
   } rsp_t;

   // --------------------------------------------------------------------------
   // Request side
   // --------------------------------------------------------------------------
   logic                  accept;
   logic                  pop;
   logic                  push;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [CNT_W-1:0]      inflight;

   // Credit check uses only registered state plus rst_n, so there is no
   // combinational path from rsp_ready to req_ready.
   assign req_ready = rst_n & (inflight < CNT_W'(RSP_DEPTH));
   assign accept    = req_valid & req_ready;
   assign in_range  = ({1'b0, req_addr} < DEPTH_LIM);
   assign idx       = req_addr[IDX_W-1:0];

   // --------------------------------------------------------------------------
   // Storage array and tag/data pipeline
   //
   // The array is zero at elaboration and is deliberately left out of reset so
   // that writes survive a reset pulse. Stage 1 captures the array read at the
   // acceptance edge; stages 2..READ_LATENCY are plain delay registers. Data
   // registers need no reset: vld_pipe qualifies them.
   // --------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
   rsp_t                  pipe_q [READ_LATENCY:1];
   logic [READ_LATENCY:1] vld_pipe;

   always_ff @(posedge clk) begin : mem_port
      if (accept) begin
         if (req_we && in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (req_wstrb[b]) begin
                  mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
               end
            end
         end
         pipe_q[1].is_write <= req_we;
         pipe_q[1].err      <= ~in_range;
         pipe_q[1].rdata    <= (!req_we && in_range) ? mem[idx] : '0;
      end
      for (int k = 2; k <= READ_LATENCY; k++) begin
         pipe_q[k] <= pipe_q[k-1];
      end
   end

   always_ff @(posedge clk) begin : vld_shift
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= accept;
         for (int k = 2; k <= READ_LATENCY; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
         end
      end
   end

   assign push = vld_pipe[READ_LATENCY];

   // --------------------------------------------------------------------------
   // Response FIFO (first-word fall-through, RSP_DEPTH entries)
   //
   // inflight counts everything between acceptance and pop (pipeline plus
   // FIFO), so bounding it by RSP_DEPTH means a push never finds the FIFO full.
   // --------------------------------------------------------------------------
   rsp_t             fifo_q [RSP_DEPTH];
   rsp_t             rsp_head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rsp_valid = rst_n & (fifo_cnt != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_head  = fifo_q[rd_ptr];

   always_ff @(posedge clk) begin : fifo_store
      if (push) begin
         fifo_q[wr_ptr] <= pipe_q[READ_LATENCY];
      end
   end

   always_ff @(posedge clk) begin : fifo_ctrl
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin : credit
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Outputs are forced to zero whenever no response is presented, which also
   // covers the reset period.
   assign rsp_rdata    = rsp_valid ? rsp_head.rdata    : '0;
   assign rsp_is_write = rsp_valid ? rsp_head.is_write : 1'b0;
   assign rsp_err      = rsp_valid ? rsp_head.err      : 1'b0;

   // --------------------------------------------------------------------------
   // Structural invariants
   // --------------------------------------------------------------------------
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (fifo_cnt < CNT_W'(RSP_DEPTH)));

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      inflight <= CNT_W'(RSP_DEPTH));

endmodule

// File: doc/axi4_memory_pipe.md
# axi4_memory_pipe

Pipelined, parametrised successor to the slave's single-port backing store. It accepts one read or write request per cycle over a valid/ready handshake and supports per-byte write strobes. Read latency is configurable, and out-of-range accesses are flagged. Every accepted request returns exactly one in-order response through a backpressurable response channel. It sits between the AXI4 slave channel FSMs and the storage array, so the slave can stream burst beats without stalling.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, request address width (word address).
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from request acceptance to response availability; legal range 1..4.
- STRB_WIDTH = DATA_WIDTH/8 and RSP_DEPTH = READ_LATENCY+1 are derived localparams, not overridable.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  zero-based word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  STRB_WIDTH  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for write responses and for errored reads.
- rsp_is_write  out  1  response belongs to a write.
- rsp_err  out  1  request address was ≥ DEPTH.

## Operation
- A request is accepted on a rising edge when req_valid and req_ready are both 1 and rst_n is 1.
- **Write, in range:** for each set bit of req_wstrb, the byte of mem[req_addr] is updated at the acceptance edge. Bytes with strobe 0 are untouched. An all-zero strobe is legal: no change, and a normal response is still returned.
- **Read, in range:** the array is read at the acceptance edge, then delayed through a (READ_LATENCY-1)-stage register pipeline.
- **Out of range (addr ≥ DEPTH):** the array is not accessed. The response carries rsp_err=1 and rsp_rdata=0.
- **Response path:** each accepted request enters a tag/data pipeline carrying {is_write, err, rdata}. Its output feeds a first-word-fall-through response FIFO of RSP_DEPTH entries.
- **Ordering:** responses leave in acceptance order. A response is popped when rsp_valid & rsp_ready.
- **Credit counter `inflight`** (width $clog2(RSP_DEPTH+1)):
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - req_ready = rst_n & (inflight < RSP_DEPTH).
  - This guarantees the FIFO never overflows, independent of rsp_ready.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the newly written data. A read and write are never accepted in the same cycle, because there is one request port.
- **Array contents:** initialised to 0 at elaboration. Reset does not clear the array.
- **Reset:**
  - inflight, the pipeline valid bits and the FIFO pointers clear.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_is_write=0, req_ready=0 while rst_n=0.
  - In-flight responses are discarded.
  - Writes accepted before the reset edge remain in the array.

## Timing
- Request accepted at edge N → its response is visible (rsp_valid=1) after edge N+READ_LATENCY, provided the FIFO ahead of it is empty.
- With rsp_ready held at 1: one request per cycle, sustained indefinitely, with a constant READ_LATENCY.
- With rsp_ready=0:
  - after RSP_DEPTH accepts, req_ready falls to 0 in the cycle following the last accept;
  - it rises again in the cycle after the first pop.
- rsp_* outputs hold stable while rsp_valid=1 and rsp_ready=0.
- req_ready depends only on registered state and rst_n; there is no combinational path from rsp_ready.
- First accept is possible on the first edge with rst_n=1.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with req_valid=1 → req_ready=0, rsp_valid=0, no accepts. Release → req_ready=1.
- **Full-word write/read:** write 0xDEADBEEF to addr 5 (wstrb=4'hF), then read addr 5 on the next cycle. Expect a write response with rsp_is_write=1, then rsp_rdata=0xDEADBEEF exactly READ_LATENCY cycles after the read accept. Repeat for READ_LATENCY=1 and 4.
- **Byte strobes:** write 0x11223344 to addr 0, then 0xAABBCCDD with wstrb=4'b0101 → read addr 0 returns 0x11BB33DD.
- **Out of range:** with DEPTH=1000, ADDR_WIDTH=10, write then read addr 1020 → both responses have rsp_err=1, rsp_rdata=0. A read of addr 999 is unaffected.
- **Backpressure:** rsp_ready=0 with continuous read requests → exactly RSP_DEPTH accepts, then req_ready=0. Raise rsp_ready → responses emerge in order with no loss or duplication.
- **Reset mid-burst:** 3 reads in flight, pulse rst_n low for 1 cycle → no stale responses appear afterwards. Earlier writes are still readable.
